split3: RTL and testbench

Three-output routing split that drains one input FIFO and steers each packet to one of three output FIFOs (east, west, local) based on a signed dx field in the packet header. It is the fan-out counterpart of the three-input merge in the router datapath: merges combine traffic into a direction, split3 distributes traffic leaving a buffer. Forwarded packets have dx stepped one hop toward zero.

---
 rtl/split3.sv | 156 +++++++++++++++
 tb/tb_split3.sv | 399 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/split3.sv
// split3: drains one input FIFO and steers each packet east/west/local by its signed dx field.
// Define SPLIT3_STATS_EN to add saturating per-port packet counters (count_a/b/c).
module split3 #(
   parameter int unsigned DATA_WIDTH  = 32,
   parameter int unsigned DX_WIDTH    = 9,
   parameter int unsigned COUNT_WIDTH = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [DATA_WIDTH-1:0]  din,
   input  logic                   buffer_in_empty,
   input  logic                   buffer_a_full,
   input  logic                   buffer_b_full,
   input  logic                   buffer_c_full,
   output logic                   read_en,
   output logic [DATA_WIDTH-1:0]  dout,
   output logic                   wen_a,
   output logic                   wen_b,
   output logic                   wen_c
`ifdef SPLIT3_STATS_EN
   ,
   output logic [COUNT_WIDTH-1:0] count_a,
   output logic [COUNT_WIDTH-1:0] count_b,
   output logic [COUNT_WIDTH-1:0] count_c
`endif
);

   localparam int unsigned DxLsb = DATA_WIDTH - DX_WIDTH;

   typedef enum logic [1:0] {StIdle, StFetch, StRoute} state_e;
   typedef enum logic [1:0] {DestA, DestB, DestC} dest_e;

   state_e                 state_q, state_d;
   dest_e                  dest_q, dest_d;
   logic [DATA_WIDTH-1:0]  hold_q, hold_d;
   logic [DATA_WIDTH-1:0]  dout_q, dout_d;
   logic                   read_en_q, read_en_d;
   logic [2:0]             wen_q, wen_d;

   logic signed [DX_WIDTH-1:0] dx_in;
   logic                       dest_full;
   logic [2:0]                 dest_onehot;

   assign dx_in = din[DATA_WIDTH-1:DxLsb];

   always_comb begin
      dest_full   = 1'b0;
      dest_onehot = 3'b000;
      unique case (dest_q)
         DestA: begin
            dest_full   = buffer_a_full;
            dest_onehot = 3'b001;
         end
         DestB: begin
            dest_full   = buffer_b_full;
            dest_onehot = 3'b010;
         end
         DestC: begin
            dest_full   = buffer_c_full;
            dest_onehot = 3'b100;
         end
         default: begin
            dest_full   = 1'b1;
            dest_onehot = 3'b000;
         end
      endcase
   end

   always_comb begin
      state_d   = state_q;
      dest_d    = dest_q;
      hold_d    = hold_q;
      dout_d    = dout_q;
      read_en_d = 1'b0;
      wen_d     = 3'b000;
      unique case (state_q)
         StIdle: begin
            if (!buffer_in_empty) begin
               read_en_d = 1'b1;
               state_d   = StFetch;
            end
         end
         StFetch: begin
            hold_d = din;
            // Step dx one hop toward zero; payload below dx is untouched.
            if (dx_in > 0) begin
               dest_d                      = DestA;
               hold_d[DATA_WIDTH-1:DxLsb] = dx_in - DX_WIDTH'(1);
            end else if (dx_in < 0) begin
               dest_d                      = DestB;
               hold_d[DATA_WIDTH-1:DxLsb] = dx_in + DX_WIDTH'(1);
            end else begin
               dest_d = DestC;
            end
            state_d = StRoute;
         end
         StRoute: begin
            // Only the selected port's full flag matters; a stall issues no read.
            if (!dest_full) begin
               dout_d = hold_q;
               wen_d  = dest_onehot;
               if (!buffer_in_empty) begin
                  read_en_d = 1'b1;
                  state_d   = StFetch;
               end else begin
                  state_d = StIdle;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(negedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= StIdle;
         dest_q    <= DestC;
         hold_q    <= '0;
         dout_q    <= '0;
         read_en_q <= 1'b0;
         wen_q     <= 3'b000;
      end else begin
         state_q   <= state_d;
         dest_q    <= dest_d;
         hold_q    <= hold_d;
         dout_q    <= dout_d;
         read_en_q <= read_en_d;
         wen_q     <= wen_d;
      end
   end

   assign read_en = read_en_q;
   assign dout    = dout_q;
   assign wen_a   = wen_q[0];
   assign wen_b   = wen_q[1];
   assign wen_c   = wen_q[2];

`ifdef SPLIT3_STATS_EN
   logic [COUNT_WIDTH-1:0] cnt_q [3];

   always_ff @(negedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 3; i++) cnt_q[i] <= '0;
      end else begin
         for (int i = 0; i < 3; i++) begin
            if (wen_d[i] && (cnt_q[i] != '1)) cnt_q[i] <= cnt_q[i] + COUNT_WIDTH'(1);
         end
      end
   end

   assign count_a = cnt_q[0];
   assign count_b = cnt_q[1];
   assign count_c = cnt_q[2];
`endif

endmodule

// File: tb/tb_split3.sv
// Bench for split3: FIFO-driven directed and random traffic checked against a dx routing model.
module tb_split3;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] din = '0;
   logic        buffer_in_empty = 1'b1;
   logic        buffer_a_full = 1'b0;
   logic        buffer_b_full = 1'b0;
   logic        buffer_c_full = 1'b0;
   logic        read_en;
   logic [31:0] dout;
   logic        wen_a, wen_b, wen_c;
`ifdef SPLIT3_STATS_EN
   logic [15:0] count_a, count_b, count_c;
`endif

   split3 dut (
      .clk             (clk),
      .rst             (rst),
      .din             (din),
      .buffer_in_empty (buffer_in_empty),
      .buffer_a_full   (buffer_a_full),
      .buffer_b_full   (buffer_b_full),
      .buffer_c_full   (buffer_c_full),
      .read_en         (read_en),
      .dout            (dout),
      .wen_a           (wen_a),
      .wen_b           (wen_b),
      .wen_c           (wen_c)
`ifdef SPLIT3_STATS_EN
      ,
      .count_a         (count_a),
      .count_b         (count_b),
      .count_c         (count_c)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      int          port;
      logic [31:0] data;
      int          cyc;
   } wr_t;

   int          errors = 0;
   int          checks = 0;
   int          cyc = 0;
   int          underflows = 0;
   int          multi_hot = 0;
   int          full_viol = 0;
   int          exp_cnt [3] = '{0, 0, 0};
   logic [31:0] fifo_q [$];
   int          rd_log [$];
   wr_t         wr_log [$];

   // Input FIFO model and output monitor; DUT outputs change on falling edges.
   always @(posedge clk) begin
      wr_t w;
      cyc = cyc + 1;
      if (read_en) begin
         rd_log.push_back(cyc);
         if (fifo_q.size() > 0) din = fifo_q.pop_front();
         else underflows++;
      end
      buffer_in_empty = (fifo_q.size() == 0);
      if (wen_a || wen_b || wen_c) begin
         w.port = wen_a ? 0 : (wen_b ? 1 : 2);
         w.data = dout;
         w.cyc  = cyc;
         wr_log.push_back(w);
         if ((32'(wen_a) + 32'(wen_b) + 32'(wen_c)) > 1) multi_hot++;
         if ((wen_a && buffer_a_full) || (wen_b && buffer_b_full) || (wen_c && buffer_c_full))
            full_viol++;
      end
   end

   // Reference: positive dx -> east (dx-1), negative -> west (dx+1), zero -> local unchanged.
   function automatic logic [33:0] ref_route(input logic [31:0] d);
      int         dx;
      logic [1:0] port;
      dx = $signed(d[31:23]);
      if (dx > 0) begin
         port = 2'd0;
         dx   = dx - 1;
      end else if (dx < 0) begin
         port = 2'd1;
         dx   = dx + 1;
      end else begin
         port = 2'd2;
      end
      return {port, 9'(dx), d[22:0]};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push_pkt(input logic [31:0] d);
      logic [33:0] r;
      r = ref_route(d);
      fifo_q.push_back(d);
      exp_cnt[r[33:32]]++;
   endtask

   task automatic wait_writes(input int target, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 300; i++) begin
         if (wr_log.size() >= target) begin
            ok = 1'b1;
            break;
         end
         step();
      end
   endtask

   task automatic test_reset();
      step();
      step();
      checks++;
      if (read_en !== 1'b0 || {wen_a, wen_b, wen_c} !== 3'b000 || dout !== 32'h0) begin
         errors++;
         $display("FAIL reset_outputs: read_en=%b wen=%b%b%b dout=%h, required all zero",
                  read_en, wen_a, wen_b, wen_c, dout);
      end
`ifdef SPLIT3_STATS_EN
      checks++;
      if (count_a !== 16'h0 || count_b !== 16'h0 || count_c !== 16'h0) begin
         errors++;
         $display("FAIL reset_counts: %0d/%0d/%0d, required 0/0/0", count_a, count_b, count_c);
      end
`endif
      rst = 1'b0;
      repeat (3) step();
      checks++;
      if (read_en !== 1'b0) begin
         errors++;
         $display("FAIL idle_empty: read_en=%b with empty input, required 0", read_en);
      end
   endtask

   task automatic test_single(input string name, input logic [31:0] d, input int port,
                              input logic [31:0] data);
      int  base, rd0;
      bit  ok;
      wr_t w;
      base = wr_log.size();
      rd0  = rd_log.size();
      push_pkt(d);
      wait_writes(base + 1, ok);
      checks++;
      if (!ok || rd_log.size() <= rd0) begin
         errors++;
         $display("FAIL %s_timeout: writes=%0d reads=%0d, required a read and a write",
                  name, wr_log.size() - base, rd_log.size() - rd0);
         return;
      end
      w = wr_log[base];
      checks++;
      if (w.port !== port || w.data !== data) begin
         errors++;
         $display("FAIL %s_route: port=%0d dout=%h, required port=%0d dout=%h",
                  name, w.port, w.data, port, data);
      end
      checks++;
      if (w.cyc - rd_log[rd0] !== 2) begin
         errors++;
         $display("FAIL %s_latency: %0d cycles, required 2", name, w.cyc - rd_log[rd0]);
      end
      step();
      checks++;
      if ({wen_a, wen_b, wen_c} !== 3'b000) begin
         errors++;
         $display("FAIL %s_pulse: wen=%b%b%b after write, required 000", name, wen_a, wen_b, wen_c);
      end
   endtask

   task automatic test_backpressure();
      int  rd0, base;
      bit  ok;
      base = wr_log.size();
      rd0  = rd_log.size();
      buffer_a_full = 1'b1;
      push_pkt(32'h00812345);
      push_pkt(32'h00000012);
      for (int i = 0; i < 20 && rd_log.size() <= rd0; i++) step();
      checks++;
      if (rd_log.size() <= rd0) begin
         errors++;
         $display("FAIL bp_first_read: no read_en seen, required one");
      end
      for (int k = 1; k <= 6; k++) begin
         step();
         buffer_b_full = 1'($urandom_range(0, 1));
         checks++;
         if (read_en !== 1'b0 || {wen_a, wen_b, wen_c} !== 3'b000) begin
            errors++;
            $display("FAIL bp_stall_%0d: read_en=%b wen=%b%b%b, required 0 000",
                     k, read_en, wen_a, wen_b, wen_c);
         end
      end
      buffer_a_full = 1'b0;
      step();
      buffer_b_full = 1'b0;
      checks++;
      if (wen_a !== 1'b1 || dout !== 32'h00012345 || read_en !== 1'b1) begin
         errors++;
         $display("FAIL bp_release: wen_a=%b dout=%h read_en=%b, required 1 00012345 1",
                  wen_a, dout, read_en);
      end
      wait_writes(base + 2, ok);
      checks++;
      if (!ok || wr_log[base + 1].port !== 2 || wr_log[base + 1].data !== 32'h00000012) begin
         errors++;
         $display("FAIL bp_second: ok=%0b writes=%0d, required local write of 00000012",
                  ok, wr_log.size() - base);
      end
   endtask

   task automatic test_reset_mid();
      int  rd0, base;
      bit  ok;
      rd0 = rd_log.size();
      buffer_a_full = 1'b1;
      push_pkt(32'h00812345);
      for (int i = 0; i < 20 && rd_log.size() <= rd0; i++) step();
      repeat (3) step();
      #2;
      rst = 1'b1;
      #1;
      exp_cnt = '{0, 0, 0};
      checks++;
      if (read_en !== 1'b0 || {wen_a, wen_b, wen_c} !== 3'b000 || dout !== 32'h0) begin
         errors++;
         $display("FAIL midrst_outputs: read_en=%b wen=%b%b%b dout=%h, required all zero",
                  read_en, wen_a, wen_b, wen_c, dout);
      end
`ifdef SPLIT3_STATS_EN
      checks++;
      if (count_a !== 16'h0 || count_b !== 16'h0 || count_c !== 16'h0) begin
         errors++;
         $display("FAIL midrst_counts: %0d/%0d/%0d, required 0/0/0", count_a, count_b, count_c);
      end
`endif
      step();
      step();
      buffer_a_full = 1'b0;
      rst = 1'b0;
      base = wr_log.size();
      repeat (6) step();
      checks++;
      if (wr_log.size() !== base) begin
         errors++;
         $display("FAIL midrst_discard: %0d writes after reset, required 0", wr_log.size() - base);
      end
      push_pkt(32'h00000077);
      wait_writes(base + 1, ok);
      checks++;
      if (!ok || wr_log[base].port !== 2 || wr_log[base].data !== 32'h00000077) begin
         errors++;
         $display("FAIL midrst_resume: ok=%0b, required local write of 00000077", ok);
      end
   endtask

   task automatic test_back_to_back();
      int          base;
      bit          ok, found;
      logic [31:0] d [4];
      logic [33:0] r;
      d = '{32'h01800001, 32'hFF800002, 32'h00000003, 32'h7F800004};
      base = wr_log.size();
      for (int i = 0; i < 4; i++) push_pkt(d[i]);
      wait_writes(base + 4, ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL b2b_timeout: %0d writes, required 4", wr_log.size() - base);
         return;
      end
      for (int i = 0; i < 4; i++) begin
         r = ref_route(d[i]);
         checks++;
         if (wr_log[base + i].port !== int'(r[33:32]) || wr_log[base + i].data !== r[31:0]) begin
            errors++;
            $display("FAIL b2b_route_%0d: port=%0d dout=%h, required port=%0d dout=%h", i,
                     wr_log[base + i].port, wr_log[base + i].data, r[33:32], r[31:0]);
         end
      end
      for (int i = 1; i < 4; i++) begin
         checks++;
         if (wr_log[base + i].cyc - wr_log[base + i - 1].cyc !== 2) begin
            errors++;
            $display("FAIL b2b_spacing_%0d: %0d cycles, required 2", i,
                     wr_log[base + i].cyc - wr_log[base + i - 1].cyc);
         end
         found = 1'b0;
         foreach (rd_log[j]) if (rd_log[j] == wr_log[base + i - 1].cyc) found = 1'b1;
         checks++;
         if (!found) begin
            errors++;
            $display("FAIL b2b_coincident_%0d: read_en=0 at write, required 1", i);
         end
      end
   endtask

   task automatic test_random();
      logic [33:0] exp_q [$];
      logic [31:0] d;
      int          base, pushed;
      bit          ok;
      base   = wr_log.size();
      pushed = 0;
      for (int c = 0; c < 600 && pushed < 40; c++) begin
         if ($urandom_range(0, 2) == 0) begin
            d = $urandom;
            case ($urandom_range(0, 3))
               0: d[31:23] = 9'h000;
               1: d[31:23] = 9'h100;
               2: d[31:23] = 9'h0FF;
               default: ;
            endcase
            push_pkt(d);
            exp_q.push_back(ref_route(d));
            pushed++;
         end
         buffer_a_full = ($urandom_range(0, 3) == 0);
         buffer_b_full = ($urandom_range(0, 3) == 0);
         buffer_c_full = ($urandom_range(0, 3) == 0);
         step();
      end
      buffer_a_full = 1'b0;
      buffer_b_full = 1'b0;
      buffer_c_full = 1'b0;
      wait_writes(base + pushed, ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL rand_timeout: %0d writes, required %0d", wr_log.size() - base, pushed);
      end
      for (int i = 0; i < pushed && base + i < wr_log.size(); i++) begin
         checks++;
         if (wr_log[base + i].port !== int'(exp_q[i][33:32]) ||
             wr_log[base + i].data !== exp_q[i][31:0]) begin
            errors++;
            $display("FAIL rand_pkt_%0d: port=%0d dout=%h, required port=%0d dout=%h", i,
                     wr_log[base + i].port, wr_log[base + i].data, exp_q[i][33:32],
                     exp_q[i][31:0]);
         end
      end
   endtask

   task automatic test_counts();
`ifdef SPLIT3_STATS_EN
      step();
      checks++;
      if (count_a !== 16'(exp_cnt[0]) || count_b !== 16'(exp_cnt[1]) ||
          count_c !== 16'(exp_cnt[2])) begin
         errors++;
         $display("FAIL counts: %0d/%0d/%0d, required %0d/%0d/%0d", count_a, count_b, count_c,
                  exp_cnt[0], exp_cnt[1], exp_cnt[2]);
      end
`endif
   endtask

   task automatic test_integrity();
      step();
      checks++;
      if (underflows !== 0 || multi_hot !== 0 || full_viol !== 0) begin
         errors++;
         $display("FAIL integrity: underflows=%0d multi_hot=%0d full_writes=%0d, required 0/0/0",
                  underflows, multi_hot, full_viol);
      end
   endtask

   initial begin
      test_reset();
      test_single("east", 32'h01800ABC, 0, 32'h01000ABC);
      test_single("west", 32'hFF8000FF, 1, 32'h000000FF);
      test_single("west_min", 32'h80000001, 1, 32'h80800001);
      test_single("local", 32'h00000055, 2, 32'h00000055);
      test_backpressure();
      test_reset_mid();
      test_back_to_back();
      test_random();
      test_counts();
      test_integrity();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

endmodule
